// File: rtl/rv_bus_pkg.sv
// Shared definitions for the VexRiscv iBus/dBus to single-port memory arbiter:
// source encodings, access-size codes and the byte-lane write mask helper.
package rv_bus_pkg;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_INV  = 2'b11;

  localparam int MEM_LAT_MAX = 4;

  // A halfword at lane 3 is truncated to lane 3 only; the invalid size writes nothing.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lane;
      SZ_HALF: mask = 4'b0011 << lane;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rv_rsp_tag_pipe.sv
// Fixed-depth {valid,src} shift register tracking reads in flight through the memory,
// so each returning word can be steered to the bus that issued it.
module rv_rsp_tag_pipe
  import rv_bus_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic CLK,
  input  logic RST_X,
  input  logic push,
  input  logic push_src,
  output logic pop_valid,
  output logic pop_src
);

  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] src_q, src_d;

  always_comb begin
    vld_d    = vld_q;
    src_d    = src_q;
    vld_d[0] = push;
    src_d[0] = push_src;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      src_d[i] = src_q[i-1];
    end
  end

  // Async clear drops every in-flight read so nothing is delivered after a reset.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      vld_q <= '0;
      src_q <= {LAT{SRC_I}};
    end else begin
      vld_q <= vld_d;
      src_q <= src_d;
    end
  end

  assign pop_valid = vld_q[LAT-1];
  assign pop_src   = src_q[LAT-1];

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the iBus and dBus,
// with pipelined response routing and a saturating conflict counter.
module rv_mem_arbiter
  import rv_bus_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             i_cmd_valid,
  output logic             i_cmd_ready,
  input  logic [31:0]      i_cmd_addr,
  output logic             i_rsp_valid,
  output logic [31:0]      i_rsp_data,
  input  logic             d_cmd_valid,
  output logic             d_cmd_ready,
  input  logic             d_cmd_wr,
  input  logic [31:0]      d_cmd_addr,
  input  logic [31:0]      d_cmd_data,
  input  logic [1:0]       d_cmd_size,
  output logic             d_rsp_valid,
  output logic [31:0]      d_rsp_data,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_we,
  output logic             m_re,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_i, gnt_d, rd_src;
  logic             tag_vld, tag_src;

  always_comb begin
    // On a conflict the source that did not win last time gets the slot.
    gnt_i = i_cmd_valid && (!d_cmd_valid || (rr_last_q == SRC_D));
    gnt_d = d_cmd_valid && !gnt_i;

    rr_last_d = rr_last_q;
    if (gnt_i)      rr_last_d = SRC_I;
    else if (gnt_d) rr_last_d = SRC_D;

    i_cmd_ready = gnt_i;
    d_cmd_ready = gnt_d;

    m_addr  = gnt_i ? i_cmd_addr : d_cmd_addr;
    m_wdata = d_cmd_data;
    m_we    = (gnt_d && d_cmd_wr) ? byte_mask(d_cmd_size, d_cmd_addr[1:0]) : 4'b0000;
    m_re    = gnt_i || (gnt_d && !d_cmd_wr);
    rd_src  = gnt_i ? SRC_I : SRC_D;

    cnt_d = cnt_q;
    if (i_cmd_valid && d_cmd_valid && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);

    i_rsp_valid = tag_vld && (tag_src == SRC_I);
    d_rsp_valid = tag_vld && (tag_src == SRC_D);
    i_rsp_data  = m_rdata;
    d_rsp_data  = m_rdata;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rr_last_q <= SRC_I;
      cnt_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;

  rv_rsp_tag_pipe #(
    .LAT (MEM_LAT)
  ) u_tag_pipe (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .push      (m_re),
    .push_src  (rd_src),
    .pop_valid (tag_vld),
    .pop_src   (tag_src)
  );

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: a MEM_LAT=1/CNT_W=32 instance and a MEM_LAT=3/CNT_W=4
// instance share the same stimulus, each with its own latency-matched memory model.
module tb_rv_mem_arbiter;

  logic        CLK;
  logic        RST_X;
  logic        i_cmd_valid, d_cmd_valid, d_cmd_wr;
  logic [31:0] i_cmd_addr, d_cmd_addr, d_cmd_data;
  logic [1:0]  d_cmd_size;

  logic        i_rdy1, d_rdy1, i_rv1, d_rv1, m_re1;
  logic [31:0] i_rd1, d_rd1, m_addr1, m_wdata1, m_rdata1;
  logic [3:0]  m_we1;
  logic [31:0] cnt1;

  logic        i_rdy3, d_rdy3, i_rv3, d_rv3, m_re3;
  logic [31:0] i_rd3, d_rd3, m_addr3, m_wdata3, m_rdata3;
  logic [3:0]  m_we3;
  logic [3:0]  cnt3;

  int n_checks = 0;
  int n_errors = 0;

  rv_mem_arbiter #(.MEM_LAT(1), .CNT_W(32)) u_dut1 (
    .CLK(CLK), .RST_X(RST_X),
    .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_rdy1), .i_cmd_addr(i_cmd_addr),
    .i_rsp_valid(i_rv1), .i_rsp_data(i_rd1),
    .d_cmd_valid(d_cmd_valid), .d_cmd_ready(d_rdy1), .d_cmd_wr(d_cmd_wr),
    .d_cmd_addr(d_cmd_addr), .d_cmd_data(d_cmd_data), .d_cmd_size(d_cmd_size),
    .d_rsp_valid(d_rv1), .d_rsp_data(d_rd1),
    .m_addr(m_addr1), .m_wdata(m_wdata1), .m_we(m_we1), .m_re(m_re1), .m_rdata(m_rdata1),
    .conflict_cnt(cnt1)
  );

  rv_mem_arbiter #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
    .CLK(CLK), .RST_X(RST_X),
    .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_rdy3), .i_cmd_addr(i_cmd_addr),
    .i_rsp_valid(i_rv3), .i_rsp_data(i_rd3),
    .d_cmd_valid(d_cmd_valid), .d_cmd_ready(d_rdy3), .d_cmd_wr(d_cmd_wr),
    .d_cmd_addr(d_cmd_addr), .d_cmd_data(d_cmd_data), .d_cmd_size(d_cmd_size),
    .d_rsp_valid(d_rv3), .d_rsp_data(d_rd3),
    .m_addr(m_addr3), .m_wdata(m_wdata3), .m_we(m_we3), .m_re(m_re3), .m_rdata(m_rdata3),
    .conflict_cnt(cnt3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_3C3C;
  endfunction

  // Memory models: read data appears MEM_LAT cycles after the read strobe.
  logic [31:0] mp1;
  logic [31:0] mp3 [3];
  always @(posedge CLK) begin
    if (m_re1) mp1 <= memf(m_addr1);
    mp3[0] <= m_re3 ? memf(m_addr3) : 32'h0;
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign m_rdata1 = mp1;
  assign m_rdata3 = mp3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dwr,
                       input logic [31:0] da, input logic [1:0] dsz);
    i_cmd_valid = iv;
    i_cmd_addr  = ia;
    d_cmd_valid = dv;
    d_cmd_wr    = dwr;
    d_cmd_addr  = da;
    d_cmd_size  = dsz;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dwr;
    logic [31:0] da;
    logic [1:0]  dsz;
    logic        e_irdy;
    logic        e_drdy;
    logic [3:0]  e_we;
    logic        e_re;
    logic [31:0] e_addr;
    logic        e_irsp;
    logic        e_drsp;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic dv,
                              input logic dwr, input logic [31:0] da, input logic [1:0] dsz,
                              input logic e_irdy, input logic e_drdy, input logic [3:0] e_we,
                              input logic e_re, input logic [31:0] e_addr, input logic e_irsp,
                              input logic e_drsp, input logic [31:0] e_rdata);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.dwr = dwr; v.da = da; v.dsz = dsz;
    v.e_irdy = e_irdy; v.e_drdy = e_drdy; v.e_we = e_we; v.e_re = e_re; v.e_addr = e_addr;
    v.e_irsp = e_irsp; v.e_drsp = e_drsp; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    // Responses on the MEM_LAT=1 instance belong to the previous row's grant.
    tbl[0]  = mk(0, 32'h000, 0, 0, 32'h000, 2'b10, 0, 0, 4'b0000, 0, 32'h000, 0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h100, 0, 0, 32'h000, 2'b10, 1, 0, 4'b0000, 1, 32'h100, 0, 0, 32'h0);
    tbl[2]  = mk(1, 32'h104, 0, 0, 32'h000, 2'b10, 1, 0, 4'b0000, 1, 32'h104, 1, 0, memf(32'h100));
    tbl[3]  = mk(0, 32'h000, 0, 0, 32'h000, 2'b10, 0, 0, 4'b0000, 0, 32'h000, 1, 0, memf(32'h104));
    tbl[4]  = mk(1, 32'h000, 1, 0, 32'h200, 2'b10, 0, 1, 4'b0000, 1, 32'h200, 0, 0, 32'h0);
    tbl[5]  = mk(1, 32'h000, 1, 0, 32'h200, 2'b10, 1, 0, 4'b0000, 1, 32'h000, 0, 1, memf(32'h200));
    tbl[6]  = mk(1, 32'h000, 1, 0, 32'h200, 2'b10, 0, 1, 4'b0000, 1, 32'h200, 1, 0, memf(32'h000));
    tbl[7]  = mk(1, 32'h000, 1, 0, 32'h200, 2'b10, 1, 0, 4'b0000, 1, 32'h000, 0, 1, memf(32'h200));
    tbl[8]  = mk(0, 32'h000, 0, 0, 32'h000, 2'b10, 0, 0, 4'b0000, 0, 32'h000, 1, 0, memf(32'h000));
    tbl[9]  = mk(0, 32'h000, 1, 1, 32'h203, 2'b00, 0, 1, 4'b1000, 0, 32'h203, 0, 0, 32'h0);
    tbl[10] = mk(0, 32'h000, 1, 1, 32'h202, 2'b01, 0, 1, 4'b1100, 0, 32'h202, 0, 0, 32'h0);
    tbl[11] = mk(0, 32'h000, 1, 1, 32'h200, 2'b10, 0, 1, 4'b1111, 0, 32'h200, 0, 0, 32'h0);
    tbl[12] = mk(0, 32'h000, 1, 1, 32'h201, 2'b11, 0, 1, 4'b0000, 0, 32'h201, 0, 0, 32'h0);
    tbl[13] = mk(0, 32'h000, 1, 1, 32'h203, 2'b01, 0, 1, 4'b1000, 0, 32'h203, 0, 0, 32'h0);
    tbl[14] = mk(0, 32'h000, 0, 0, 32'h000, 2'b10, 0, 0, 4'b0000, 0, 32'h000, 0, 0, 32'h0);

    RST_X      = 1'b0;
    d_cmd_data = 32'hDEAD_BEEF;
    drive(0, 0, 0, 0, 0, 2'b10);

    // Reset held: valids toggled, nothing may come back and the counter stays clear.
    @(posedge CLK); #1 drive(1, 32'h040, 0, 0, 32'h300, 2'b10);
    @(negedge CLK);
    chk("rst_i_rsp_valid", i_rv1, 0);
    chk("rst_cnt1", cnt1, 0);
    @(posedge CLK); #1 drive(1, 32'h040, 1, 0, 32'h300, 2'b10);
    @(negedge CLK);
    chk("rst_d_wins_first1", d_rdy1, 1);
    chk("rst_d_wins_first3", d_rdy3, 1);
    chk("rst_d_rsp_valid", d_rv1, 0);
    chk("rst_i_rsp_valid3", i_rv3, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_cnt1_held", cnt1, 0);
    chk("rst_cnt3_held", cnt3, 0);
    @(posedge CLK); #1 drive(0, 0, 0, 0, 0, 2'b10);
    RST_X = 1'b1;

    for (int n = 0; n < 15; n++) begin
      @(posedge CLK); #1 drive(tbl[n].iv, tbl[n].ia, tbl[n].dv, tbl[n].dwr, tbl[n].da, tbl[n].dsz);
      @(negedge CLK);
      chk($sformatf("v%0d_i_ready", n), i_rdy1, tbl[n].e_irdy);
      chk($sformatf("v%0d_d_ready", n), d_rdy1, tbl[n].e_drdy);
      chk($sformatf("v%0d_m_we", n), m_we1, tbl[n].e_we);
      chk($sformatf("v%0d_m_re", n), m_re1, tbl[n].e_re);
      if (tbl[n].e_re || tbl[n].dv) begin
        chk($sformatf("v%0d_m_addr", n), m_addr1, tbl[n].e_addr);
        chk($sformatf("v%0d_m_wdata", n), m_wdata1, 32'hDEAD_BEEF);
      end
      chk($sformatf("v%0d_i_rsp_valid", n), i_rv1, tbl[n].e_irsp);
      chk($sformatf("v%0d_d_rsp_valid", n), d_rv1, tbl[n].e_drsp);
      if (tbl[n].e_irsp) chk($sformatf("v%0d_i_rsp_data", n), i_rd1, tbl[n].e_rdata);
      if (tbl[n].e_drsp) chk($sformatf("v%0d_d_rsp_data", n), d_rd1, tbl[n].e_rdata);
      chk($sformatf("v%0d_i_ready_lat3", n), i_rdy3, tbl[n].e_irdy);
      chk($sformatf("v%0d_d_ready_lat3", n), d_rdy3, tbl[n].e_drdy);
      chk($sformatf("v%0d_m_we_lat3", n), m_we3, tbl[n].e_we);
      chk($sformatf("v%0d_m_re_lat3", n), m_re3, tbl[n].e_re);
      if (tbl[n].e_re || tbl[n].dv) begin
        chk($sformatf("v%0d_m_addr_lat3", n), m_addr3, tbl[n].e_addr);
        chk($sformatf("v%0d_m_wdata_lat3", n), m_wdata3, 32'hDEAD_BEEF);
      end
    end
    chk("conflict_cnt1_after_4", cnt1, 4);
    chk("conflict_cnt3_after_4", cnt3, 4);

    // Alternating conflicting reads: last grant was a dBus write, so iBus wins first.
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1 if (k < 6) drive(1, 32'h040, 1, 0, 32'h300, 2'b10);
         else       drive(0, 0, 0, 0, 0, 2'b10);
      @(negedge CLK);
      if (k < 6) begin
        chk($sformatf("alt%0d_i_ready3", k), i_rdy3, (k % 2) == 0);
        chk($sformatf("alt%0d_d_ready3", k), d_rdy3, (k % 2) == 1);
      end
      chk($sformatf("alt%0d_i_rsp3", k), i_rv3, (k >= 3 && k <= 8 && ((k - 3) % 2) == 0));
      chk($sformatf("alt%0d_d_rsp3", k), d_rv3, (k >= 3 && k <= 8 && ((k - 3) % 2) == 1));
      if (k >= 3 && k <= 8)
        chk($sformatf("alt%0d_rsp_data3", k), ((k - 3) % 2 == 0) ? i_rd3 : d_rd3,
            ((k - 3) % 2 == 0) ? memf(32'h040) : memf(32'h300));
      chk($sformatf("alt%0d_i_rsp1", k), i_rv1, (k >= 1 && k <= 6 && ((k - 1) % 2) == 0));
      chk($sformatf("alt%0d_d_rsp1", k), d_rv1, (k >= 1 && k <= 6 && ((k - 1) % 2) == 1));
    end
    chk("conflict_cnt1_after_10", cnt1, 10);
    chk("conflict_cnt3_after_10", cnt3, 10);

    repeat (6) begin
      @(posedge CLK); #1 drive(1, 32'h040, 1, 0, 32'h300, 2'b10);
    end
    @(posedge CLK); #1 drive(0, 0, 0, 0, 0, 2'b10);
    @(negedge CLK);
    chk("conflict_cnt1_16", cnt1, 16);
    chk("conflict_cnt3_saturated", cnt3, 15);
    repeat (4) @(posedge CLK);

    // Two reads in flight, then reset: neither may surface on either instance.
    @(posedge CLK); #1 drive(1, 32'h040, 0, 0, 32'h300, 2'b10);
    @(posedge CLK); #1 drive(0, 32'h040, 1, 0, 32'h300, 2'b10);
    @(posedge CLK); #1 drive(0, 0, 0, 0, 0, 2'b10);
    #1 RST_X = 1'b0;
    @(negedge CLK);
    chk("midrst_d_rsp1", d_rv1, 0);
    chk("midrst_i_rsp3", i_rv3, 0);
    chk("midrst_d_rsp3", d_rv3, 0);
    chk("midrst_cnt3", cnt3, 0);
    repeat (2) @(posedge CLK);
    #1 RST_X = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("post_rst%0d_i_rsp3", k), i_rv3, 0);
      chk($sformatf("post_rst%0d_d_rsp3", k), d_rv3, 0);
      chk($sformatf("post_rst%0d_rsp1", k), i_rv1 | d_rv1, 0);
    end
    chk("post_rst_cnt1", cnt1, 0);
    @(posedge CLK); #1 drive(1, 32'h040, 1, 0, 32'h300, 2'b10);
    @(negedge CLK);
    chk("post_rst_d_wins1", d_rdy1, 1);
    chk("post_rst_d_wins3", d_rdy3, 1);
    @(posedge CLK); #1 drive(0, 0, 0, 0, 0, 2'b10);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
